// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between the CPU MEM stage and a DMA burst master
//
// Purpose:
//   The CPU owns dmem by default and its accesses pass through combinationally.
//   A DMA burst takes dmem for len consecutive cycles and stalls the CPU
//   pipeline while it runs. A saturating starvation counter bounds how long
//   a pending DMA request may wait behind continuous CPU traffic.
//
// Ports:
//   clk, reset                      clock (rising edge), asynchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  MEM stage access request
//   cpu_rdata                       load data back to the pipeline
//   cpu_stall                       freeze F/D/E/M; CPU access not performed this cycle
//   dma_req/dma_we/dma_addr/dma_len burst request (held until dma_done)
//   dma_wdata/dma_rdata             per-beat write/read data
//   dma_ack                         beat performed this cycle
//   dma_done                        pulse with the last beat's ack
//   mem_we/mem_addr/mem_wdata       to dmem
//   mem_rdata                       from dmem (asynchronous read)
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LENW         = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_stall,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [AW-1:0]   dma_addr,
  input  logic [LENW-1:0] dma_len,
  input  logic [DW-1:0]   dma_wdata,
  output logic [DW-1:0]   dma_rdata,
  output logic            dma_ack,
  output logic            dma_done,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int SCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE      = 1'b0,
    DMA_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [LENW-1:0] beat_q, beat_d;
  logic [LENW-1:0] len_q, len_d;
  logic [AW-1:0]   base_q, base_d;
  logic            we_q, we_d;
  logic [SCW-1:0]  starve_q, starve_d;

  logic starved;
  logic last_beat;

  assign starved   = (starve_q == SCW'(STARVE_LIMIT));
  assign last_beat = (beat_q == (len_q - LENW'(1)));

  // Datapath muxing. The CPU path is purely combinational so loads and
  // stores see no added latency while the arbiter is idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rdata = mem_rdata;
    dma_rdata = mem_rdata;
    cpu_stall = 1'b0;
    dma_ack   = 1'b0;
    dma_done  = 1'b0;
    if (state_q == DMA_BURST) begin
      mem_we    = we_q;
      // Byte address of the current word; wraps modulo 2**AW.
      mem_addr  = base_q + (AW'(beat_q) << 2);
      mem_wdata = dma_wdata;
      dma_ack   = 1'b1;
      dma_done  = last_beat;
      cpu_stall = cpu_req;
    end else begin
      mem_we = cpu_req & cpu_we;
    end
    // The state flop is already held at IDLE by the async reset; this also
    // blocks a CPU store that happens to be presented while reset is low.
    if (!reset) begin
      mem_we = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    len_d    = len_q;
    base_d   = base_q;
    we_d     = we_q;
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (dma_req && (!cpu_req || starved)) begin
        state_d  = DMA_BURST;
        base_d   = dma_addr;
        we_d     = dma_we;
        len_d    = (dma_len == '0) ? LENW'(1) : dma_len;
        beat_d   = '0;
        starve_d = '0;
      end else if (dma_req && cpu_req) begin
        // Reaching this branch implies !starved, so the count saturates.
        starve_d = starve_q + SCW'(1);
      end
    end else begin
      // Leaving from the last beat always passes through one IDLE cycle,
      // which is what guarantees the CPU a slot between bursts.
      if (last_beat) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + LENW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      len_q    <= LENW'(1);
      base_q   <= '0;
      we_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      base_q   <= base_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LENW   = 5;
  localparam int STARVE = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            cpu_req, cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata, cpu_rdata;
  logic            cpu_stall;
  logic            dma_req, dma_we;
  logic [AW-1:0]   dma_addr;
  logic [LENW-1:0] dma_len;
  logic [DW-1:0]   dma_wdata, dma_rdata;
  logic            dma_ack, dma_done;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .LENW(LENW), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_done(dma_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem stand-in: 256 words, asynchronous read, indexed by word address bits.
  logic [DW-1:0] dmem [256];
  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Reference: expected beats queued when the model decides a burst is accepted.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mdl_b;
  int          busy = 0;
  int          held = 0;
  int          mdl_n;
  logic [31:0] ref_mem [256];
  bit          ref_valid [256];
  bit          saw_done = 0;

  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      busy = 0;
      held = 0;
    end else if (busy > 0) begin
      busy--;
    end else if (dma_req) begin
      if (!cpu_req || held == STARVE) begin
        mdl_n = (dma_len == 0) ? 1 : int'(dma_len);
        for (int i = 0; i < mdl_n; i++) begin
          mdl_b.addr = dma_addr + 32'(4 * i);
          mdl_b.we   = dma_we;
          mdl_b.last = (i == mdl_n - 1);
          exp_q.push_back(mdl_b);
        end
        busy = mdl_n;
        held = 0;
      end else begin
        held++;
      end
    end
  end

  beat_t mon_e;
  int    mon_i;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_dma_ack", 32'(dma_ack), 0);
      chk("rst_cpu_stall", 32'(cpu_stall), 0);
      chk("rst_dma_done", 32'(dma_done), 0);
    end else if (dma_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got dma_ack=1 expected 0 at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_i = int'(mon_e.addr[9:2]);
        chk("beat_addr", mem_addr, mon_e.addr);
        chk("beat_we", 32'(mem_we), 32'(mon_e.we));
        chk("beat_done", 32'(dma_done), 32'(mon_e.last));
        chk("beat_stall", 32'(cpu_stall), 32'(cpu_req));
        if (mon_e.we) begin
          chk("beat_wdata", mem_wdata, dma_wdata);
          ref_mem[mon_i]   = dma_wdata;
          ref_valid[mon_i] = 1'b1;
        end else if (ref_valid[mon_i]) begin
          chk("beat_rdata", dma_rdata, ref_mem[mon_i]);
        end
        if (dma_done) saw_done = 1'b1;
      end
    end else begin
      chk("dma_ack", 32'(dma_ack), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
      end else begin
        mon_i = int'(cpu_addr[9:2]);
        chk("idle_stall", 32'(cpu_stall), 0);
        chk("idle_done", 32'(dma_done), 0);
        chk("idle_mem_we", 32'(mem_we), 32'(cpu_req & cpu_we));
        chk("idle_mem_addr", mem_addr, cpu_addr);
        if (cpu_req && cpu_we) begin
          chk("idle_mem_wdata", mem_wdata, cpu_wdata);
          ref_mem[mon_i]   = cpu_wdata;
          ref_valid[mon_i] = 1'b1;
        end else if (cpu_req && ref_valid[mon_i]) begin
          chk("idle_cpu_rdata", cpu_rdata, ref_mem[mon_i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the held burst to finish; indices count negedges from the
  // cycle in which the request was first presented.
  task automatic dma_wait(input string nm, output int first_ack, output int done_at);
    first_ack = -1;
    done_at   = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dma_ack && first_ack < 0) first_ack = k;
      if (dma_ack && dma_done) begin
        done_at = k;
        break;
      end
      @(posedge clk);
      #1;
      dma_wdata = $urandom;
    end
    if (done_at < 0) begin
      n_checks++;
      $display("FAIL %s_timeout: got no dma_done expected one within 60 cycles", nm);
    end
  endtask

  task automatic start_dma(input logic we, input logic [31:0] addr, input logic [4:0] len);
    dma_req   = 1'b1;
    dma_we    = we;
    dma_addr  = addr;
    dma_len   = len;
    dma_wdata = $urandom;
  endtask

  int fa, da, acks, act_cycles;
  bit dma_active;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected one before 1ms");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();

    // CPU store then load, no DMA.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #3;
    chk("t1_store_we", 32'(mem_we), 1);
    chk("t1_store_stall", 32'(cpu_stall), 0);
    tick();
    cpu_we = 0;
    @(negedge clk);
    chk("t1_load", cpu_rdata, 32'hDEADBEEF);
    tick();
    cpu_req = 0;
    tick();

    // DMA write burst of 4 with CPU idle.
    start_dma(1'b1, 32'h40, 5'd4);
    dma_wait("t2", fa, da);
    chk("t2_first_ack", 32'(fa), 1);
    chk("t2_done_at", 32'(da), 4);
    tick();
    dma_req = 0;
    @(negedge clk);
    chk("t2_idle_after", 32'(dma_ack), 0);
    tick();

    // DMA read held off by continuous CPU loads.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    start_dma(1'b0, 32'h40, 5'd3);
    dma_wait("t3", fa, da);
    chk("t3_first_ack", 32'(fa), 5);
    chk("t3_done_at", 32'(da), 7);
    tick();
    dma_req = 0; cpu_req = 0;
    tick();

    // Top-of-memory bursts: len 0 acts as 1, len 2 wraps to address 0.
    start_dma(1'b0, 32'hFFFF_FFFC, 5'd0);
    dma_wait("t4a", fa, da);
    chk("t4a_single", 32'(da - fa), 0);
    tick();
    dma_req = 0;
    tick();
    start_dma(1'b0, 32'hFFFF_FFFC, 5'd2);
    dma_wait("t4b", fa, da);
    chk("t4b_len", 32'(da - fa), 1);
    tick();
    dma_req = 0;
    tick();

    // Reset during beat 2 of an 8-beat write.
    start_dma(1'b1, 32'h100, 5'd8);
    acks = 0;
    for (int k = 0; k < 20 && acks < 2; k++) begin
      @(negedge clk);
      if (dma_ack) acks++;
    end
    chk("t5_reach_beat2", 32'(acks), 2);
    @(posedge clk);
    #1;
    chk("t5_we_before", 32'(mem_we), 1);
    reset = 1'b0;
    dma_req = 0;
    #1;
    chk("t5_mem_we_drop", 32'(mem_we), 0);
    chk("t5_ack_drop", 32'(dma_ack), 0);
    tick();
    tick();
    reset = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h24; cpu_wdata = $urandom;
    @(negedge clk);
    chk("t5_cpu_stall", 32'(cpu_stall), 0);
    chk("t5_cpu_we", 32'(mem_we), 1);
    tick();
    cpu_we = 0;
    tick();

    // Back-to-back bursts with the CPU busy every cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h24;
    start_dma(1'b1, 32'h200, 5'd2);
    dma_wait("t6a", fa, da);
    chk("t6a_first_ack", 32'(fa), 5);
    chk("t6a_done_at", 32'(da), 6);
    tick();
    start_dma(1'b0, 32'h200, 5'd3);
    dma_wait("t6b", fa, da);
    chk("t6b_gap", 32'(fa), 5);
    chk("t6b_done_at", 32'(da), 7);
    tick();
    dma_req = 0; cpu_req = 0;
    tick();

    // Randomized traffic.
    saw_done = 0;
    dma_active = 0;
    act_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = $urandom & 32'hFFFF_FFFC;
      cpu_wdata = $urandom;
      dma_wdata = $urandom;
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        dma_req = 0;
        dma_active = 0;
        saw_done = 0;
      end else begin
        if (dma_active && saw_done) begin
          saw_done = 0;
          if ($urandom_range(0, 1) == 1) begin
            start_dma(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                      ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom));
            act_cycles = 0;
          end else begin
            dma_active = 0;
            dma_req = 0;
          end
        end else if (!dma_active && $urandom_range(0, 7) == 0) begin
          start_dma(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                    ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom));
          dma_active = 1;
          act_cycles = 0;
        end
        if (dma_active) begin
          act_cycles++;
          if (act_cycles > 100) begin
            n_checks++;
            $display("FAIL rnd_dma_timeout: got no dma_done expected one within 100 cycles");
            dma_active = 0;
            dma_req = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    dma_req = 0;
    cpu_req = 0;
    for (int k = 0; k < 40; k++) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
